// File: rtl/noc_packetizer.sv
// Network-interface injection stage: accepts a whole packet over valid/ready, serialises it
// into flits on a credit-based router link, and tracks downstream buffer credits.
module noc_packetizer #(
  parameter int unsigned DEST_WIDTH        = 4,
  parameter int unsigned FLIT_WIDTH        = 256,
  parameter int unsigned MAX_FLITS         = 4,
  parameter int unsigned FLIT_BUFFER_DEPTH = 2,
  localparam int unsigned LenWidth         = $clog2(MAX_FLITS + 1),
  localparam int unsigned CredWidth        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MAX_FLITS*FLIT_WIDTH-1:0] pkt_data,
  input  logic [DEST_WIDTH-1:0]           pkt_dest,
  input  logic [LenWidth-1:0]             pkt_len,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  output logic [FLIT_WIDTH-1:0]           data_out,
  output logic [DEST_WIDTH-1:0]           dest_out,
  output logic                            is_tail_out,
  output logic                            send_out,
  input  logic                            credit_in
);

  localparam logic [LenWidth-1:0]  MaxLen   = LenWidth'(MAX_FLITS);
  localparam logic [CredWidth-1:0] FullCred = CredWidth'(FLIT_BUFFER_DEPTH);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                          state_q, state_d;
  logic [MAX_FLITS*FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0]           dest_q, dest_d;
  logic [LenWidth-1:0]             len_q, len_d;
  logic [LenWidth-1:0]             idx_q, idx_d;
  logic [CredWidth-1:0]            cred_q, cred_d;
  logic [FLIT_WIDTH-1:0]           data_out_q, data_out_d;
  logic [DEST_WIDTH-1:0]           dest_out_q, dest_out_d;
  logic                            is_tail_out_q, is_tail_out_d;
  logic                            send_out_q, send_out_d;

  logic [LenWidth-1:0]   len_clamped;
  logic [FLIT_WIDTH-1:0] cur_flit;
  logic                  issue;
  logic                  is_last;
  logic                  accept;

  // Decode: clamp the offered length, pick the current flit, derive issue and ready.
  always_comb begin
    if (pkt_len == '0) begin
      len_clamped = LenWidth'(1);
    end else if (pkt_len > MaxLen) begin
      len_clamped = MaxLen;
    end else begin
      len_clamped = pkt_len;
    end

    cur_flit = '0;
    for (int unsigned k = 0; k < MAX_FLITS; k++) begin
      if (idx_q == LenWidth'(k)) begin
        cur_flit = data_q[k*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end

    // A returning credit in the same cycle can fund the issue when the counter is empty.
    issue   = (state_q == StSend) && ((cred_q != '0) || credit_in);
    is_last = (idx_q == (len_q - LenWidth'(1)));
    // Ready also while the tail is issuing, so the next packet follows with no bubble.
    pkt_ready = !rst && ((state_q == StIdle) || (issue && is_last));
    accept    = pkt_valid && pkt_ready;
  end

  // Next-state: packet capture, flit issue, output registers and credit accounting.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    dest_d        = dest_q;
    len_d         = len_q;
    idx_d         = idx_q;
    data_out_d    = data_out_q;
    dest_out_d    = dest_out_q;
    is_tail_out_d = is_tail_out_q;
    send_out_d    = issue;

    if (issue) begin
      data_out_d    = cur_flit;
      dest_out_d    = dest_q;
      is_tail_out_d = is_last;
      idx_d         = idx_q + LenWidth'(1);
      if (is_last) begin
        state_d = StIdle;
      end
    end

    // A new packet captured on the tail-issue edge overrides the return to idle.
    if (accept) begin
      state_d = StSend;
      data_d  = pkt_data;
      dest_d  = pkt_dest;
      len_d   = len_clamped;
      idx_d   = '0;
    end

    unique case ({credit_in, issue})
      2'b10:   cred_d = (cred_q == FullCred) ? cred_q : cred_q + CredWidth'(1);
      2'b01:   cred_d = cred_q - CredWidth'(1);
      default: cred_d = cred_q;
    endcase
  end

  // State and output registers with synchronous reset; reset drops any in-flight packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      data_q        <= '0;
      dest_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      cred_q        <= FullCred;
      data_out_q    <= '0;
      dest_out_q    <= '0;
      is_tail_out_q <= 1'b0;
      send_out_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      dest_q        <= dest_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      cred_q        <= cred_d;
      data_out_q    <= data_out_d;
      dest_out_q    <= dest_out_d;
      is_tail_out_q <= is_tail_out_d;
      send_out_q    <= send_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign dest_out    = dest_out_q;
  assign is_tail_out = is_tail_out_q;
  assign send_out    = send_out_q;

  // The router can never return more credits than it has buffer slots.
  a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(credit_in && (cred_q == FullCred)));

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: table-driven packets plus hand-written credit/reset sequences,
// with a flit scoreboard checked every cycle.
module tb_noc_packetizer;

  localparam int unsigned DW  = 4;
  localparam int unsigned FW  = 256;
  localparam int unsigned MF  = 4;
  localparam int unsigned FBD = 2;
  localparam int unsigned LW  = $clog2(MF + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [MF*FW-1:0] pkt_data;
  logic [DW-1:0]    pkt_dest;
  logic [LW-1:0]    pkt_len;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [FW-1:0]    data_out;
  logic [DW-1:0]    dest_out;
  logic             is_tail_out;
  logic             send_out;
  logic             credit_in;
  logic             auto_credit;
  logic             man_credit;

  // Auto mode models a router that frees a slot in the same cycle each flit arrives.
  assign credit_in = (auto_credit & send_out) | man_credit;

  always #5 clk = ~clk;

  noc_packetizer #(
    .DEST_WIDTH       (DW),
    .FLIT_WIDTH       (FW),
    .MAX_FLITS        (MF),
    .FLIT_BUFFER_DEPTH(FBD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_data   (pkt_data),
    .pkt_dest   (pkt_dest),
    .pkt_len    (pkt_len),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .data_out   (data_out),
    .dest_out   (dest_out),
    .is_tail_out(is_tail_out),
    .send_out   (send_out),
    .credit_in  (credit_in)
  );

  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_t;

  typedef struct {
    logic [LW-1:0] len;
    logic [DW-1:0] dest;
    int            n;
  } vec_t;

  flit_t exp_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;
  int    cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock, sample #1 after the edge and score any flit on the link.
  task automatic tick();
    flit_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (send_out === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errs++;
        $display("FAIL sb_unexpected cycle %0d: flit dest=%0h with nothing expected",
                 cyc, dest_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e.data || dest_out !== e.dest || is_tail_out !== e.tail) begin
          n_errs++;
          $display("FAIL sb_flit cycle %0d: got dest=%0h tail=%0b data=%0h expected dest=%0h tail=%0b data=%0h",
                   cyc, dest_out, is_tail_out, data_out[31:0], e.dest, e.tail, e.data[31:0]);
        end
      end
    end
  endtask

  task automatic drive_credit(input logic b);
    man_credit = b;
    #1;
  endtask

  task automatic expect_cyc(input logic s, input logic t, input logic r);
    chk("send_out", send_out, s);
    if (s) chk("is_tail_out", is_tail_out, t);
    chk("pkt_ready", pkt_ready, r);
  endtask

  // Present a fresh random packet and queue its expected flits.
  task automatic offer(input logic [LW-1:0] len, input logic [DW-1:0] dst, input int n);
    flit_t f;
    for (int i = 0; i < int'(MF * FW / 32); i++) pkt_data[i*32 +: 32] = $urandom();
    pkt_len  = len;
    pkt_dest = dst;
    for (int k = 0; k < n; k++) begin
      f.data = pkt_data[k*FW +: FW];
      f.dest = dst;
      f.tail = (k == n - 1);
      exp_q.push_back(f);
    end
    pkt_valid = 1'b1;
  endtask

  // Tick until the handshake edge; afterwards cyc==0 is the cycle after that edge.
  task automatic wait_accept();
    logic was_ready;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      was_ready = pkt_ready;
      tick();
      if (was_ready) done = 1'b1;
    end
    chk("accept_timeout", done, 1'b1);
    cyc = 0;
  endtask

  task automatic send_pkt(input logic [LW-1:0] len, input logic [DW-1:0] dst, input int n);
    offer(len, dst, n);
    wait_accept();
    pkt_valid = 1'b0;
  endtask

  task automatic restore_credits();
    drive_credit(1'b1);
    tick();
    tick();
    drive_credit(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{3'd1, 4'd3,  1};
    vecs[1] = '{3'd2, 4'd5,  2};
    vecs[2] = '{3'd3, 4'd9,  3};
    vecs[3] = '{3'd4, 4'd15, 4};
    vecs[4] = '{3'd0, 4'd7,  1};   // zero length treated as one
    vecs[5] = '{3'd5, 4'd2,  4};   // clamped to MAX_FLITS
    vecs[6] = '{3'd7, 4'd12, 4};

    rst = 1'b1;
    pkt_valid = 1'b0;
    pkt_data = '0;
    pkt_dest = '0;
    pkt_len = '0;
    auto_credit = 1'b0;
    man_credit = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_pkt_ready", pkt_ready, 1'b0);
    chk("rst_send_out", send_out, 1'b0);
    chk("rst_is_tail_out", is_tail_out, 1'b0);
    chk("rst_data_out_zero", data_out == '0, 1'b1);
    chk("rst_dest_out", dest_out, '0);
    rst = 1'b0;
    #1;
    chk("post_rst_pkt_ready", pkt_ready, 1'b1);

    // Table: single packets with ample credits
    auto_credit = 1'b1;
    foreach (vecs[i]) begin
      send_pkt(vecs[i].len, vecs[i].dest, vecs[i].n);
      for (int c = 1; c <= vecs[i].n + 1; c++) begin
        tick();
        expect_cyc(c <= vecs[i].n, c == vecs[i].n, c >= vecs[i].n - 1);
      end
      tick();
    end
    auto_credit = 1'b0;

    // Four flits, credit returned every cycle from cycle 2 (four credits total)
    send_pkt(3'd4, 4'ha, 4);
    for (int c = 1; c <= 6; c++) begin
      tick();
      drive_credit(c >= 2 && c <= 5);
      expect_cyc(c <= 4, c == 4, c >= 3);
    end
    drive_credit(1'b0);

    // Starvation: the preceding packet must have left exactly two credits
    send_pkt(3'd4, 4'h6, 4);
    for (int c = 1; c <= 11; c++) begin
      tick();
      drive_credit(c == 6 || c == 9);
      expect_cyc(c == 1 || c == 2 || c == 7 || c == 10, c == 10, c >= 9);
    end
    restore_credits();

    // Credit and issue together at cred==1 leave the counter at 1
    send_pkt(3'd4, 4'h9, 4);
    for (int c = 1; c <= 7; c++) begin
      tick();
      drive_credit(c == 1 || c == 5);
      expect_cyc(c == 1 || c == 2 || c == 3 || c == 6, c == 6, c >= 5);
    end
    restore_credits();

    // Back-to-back three-flit packets with valid held high
    auto_credit = 1'b1;
    offer(3'd3, 4'h1, 3);
    wait_accept();
    offer(3'd3, 4'h2, 3);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 3) pkt_valid = 1'b0;
      expect_cyc(c <= 6, c == 3 || c == 6, c == 2 || c >= 5);
    end
    auto_credit = 1'b0;

    // Reset in cycle 2 of a four-flit packet
    auto_credit = 1'b1;
    send_pkt(3'd4, 4'h5, 4);
    tick();
    expect_cyc(1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_pkt_ready", pkt_ready, 1'b0);
    tick();
    chk("mid_rst_send_out", send_out, 1'b0);
    chk("mid_rst_data_out_zero", data_out == '0, 1'b1);
    rst = 1'b0;
    auto_credit = 1'b0;
    #1;
    chk("mid_rst_release_ready", pkt_ready, 1'b1);
    exp_q.delete();

    // New packet after reset starts at flit 0 with a full credit count
    send_pkt(3'd4, 4'hc, 4);
    for (int c = 1; c <= 6; c++) begin
      tick();
      drive_credit(c == 3 || c == 4);
      expect_cyc(c == 1 || c == 2 || c == 4 || c == 5, c == 5, c >= 4);
    end
    drive_credit(1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
